// File: rtl/store_buffer_unit_if.sv
// Store-request, exception and data-memory signals of the store buffer unit.
// The slave modport is the buffer's view; the master modport is the view of
// the pipeline/memory environment around it.
interface store_buffer_unit_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    localparam int NB = DW / 8;

    logic          st_valid;
    logic          st_ready;
    logic [5:0]    st_op;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;

    logic          exc_valid;
    logic [AW-1:0] exc_addr;

    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [NB-1:0] mem_be;

    modport slave (
        input  st_valid, st_op, st_addr, st_data, mem_ready,
        output st_ready, exc_valid, exc_addr, mem_valid, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output st_valid, st_op, st_addr, st_data, mem_ready,
        input  st_ready, exc_valid, exc_addr, mem_valid, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_buffer_unit.sv
// Store buffer unit: decodes sb/sh/sw/sd into lane-aligned data and byte
// enables, raises AdES on misaligned stores, and queues stores in a combining
// FIFO that drains to data memory over valid/ready. Also flags loads that hit
// a queued word so the pipeline can stall them.
module store_buffer_unit #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    store_buffer_unit_if.slave     bus,
    input  logic [AW-1:0]          ld_addr_i,
    output logic                   ld_hit_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);
    localparam int NB  = DW / 8;
    localparam int OB  = $clog2(NB);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int WAW = AW - OB;

    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SW = 6'h2b;
    localparam logic [5:0] OP_SD = 6'h3f;

    // Entry storage and queue state
    logic [WAW-1:0]   addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [NB-1:0]    be_q   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             exc_valid_q;
    logic [AW-1:0]    exc_addr_q;

    // Decoded request
    logic [OB-1:0]  off;
    logic [WAW-1:0] word_addr;
    logic           op_legal;
    logic           misaligned;
    logic [NB-1:0]  size_be;
    logic [DW-1:0]  size_mask;
    logic [NB-1:0]  new_be;
    logic [DW-1:0]  new_data;

    // Queue control
    logic          st_ready;
    logic          mem_valid;
    logic [PW-1:0] last_idx;
    logic          accept, push, pop, combine, alloc;
    logic [DW-1:0] comb_data;

    logic unused_ld_off;
    assign unused_ld_off = ^ld_addr_i[OB-1:0];

    assign off       = bus.st_addr[OB-1:0];
    assign word_addr = bus.st_addr[AW-1:OB];
    assign last_idx  = tail_q - PW'(1);
    assign st_ready  = (count_q != CW'(DEPTH));
    assign mem_valid = (count_q != '0);

    // Decode opcode into size, alignment check and lane-shifted data/enables
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        op_legal   = 1'b0;
        misaligned = 1'b0;
        size_be    = '0;
        size_mask  = '0;
        case (bus.st_op)
            OP_SB: begin
                op_legal = 1'b1;
                size_be  = NB'(1);
            end
            OP_SH: begin
                op_legal   = 1'b1;
                size_be    = NB'(3);
                misaligned = off[0];
            end
            OP_SW: begin
                op_legal   = 1'b1;
                size_be    = NB'(15);
                misaligned = (off[1:0] != 2'b00);
            end
            OP_SD: begin
                op_legal   = (DW == 64);
                size_be    = '1;
                misaligned = (off != '0);
            end
            default: ;
        endcase
        for (int b = 0; b < NB; b++) begin
            size_mask[8*b +: 8] = {8{size_be[b]}};
        end
        new_be   = size_be << off;
        new_data = (bus.st_data & size_mask) << {off, 3'b000};
    end

    // Accept/combine/pop decisions and next pointer/count values
    always_comb begin
        accept  = bus.st_valid & st_ready & op_legal;
        push    = accept & ~misaligned;
        pop     = mem_valid & bus.mem_ready;
        // count>=2 guarantees the newest entry is not the head being presented.
        combine = push & (count_q >= CW'(2)) & (addr_q[last_idx] == word_addr);
        alloc   = push & ~combine;
        head_d  = pop   ? head_q + PW'(1) : head_q;
        tail_d  = alloc ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(alloc) - CW'(pop);
        for (int b = 0; b < NB; b++) begin
            comb_data[8*b +: 8] = new_be[b] ? new_data[8*b +: 8] : data_q[last_idx][8*b +: 8];
        end
    end

    // Pointers, count, valid bits and exception register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            exc_valid_q <= 1'b0;
            exc_addr_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            exc_valid_q <= accept & misaligned;
            if (accept & misaligned) begin
                exc_addr_q <= bus.st_addr;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
            end
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
            end
        end
    end

    // Entry payload: written on allocate, merged on combine
    // NOTE: payload arrays are not reset; valid_q and count_q alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail_q] <= word_addr;
            data_q[tail_q] <= new_data;
            be_q[tail_q]   <= new_be;
        end else if (combine) begin
            data_q[last_idx] <= comb_data;
            be_q[last_idx]   <= be_q[last_idx] | new_be;
        end
    end

    // Load hazard: any queued entry on the same word as the load
    always_comb begin
        ld_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == ld_addr_i[AW-1:OB]) begin
                ld_hit_o = 1'b1;
            end
        end
    end

    assign bus.st_ready  = st_ready;
    assign bus.exc_valid = exc_valid_q;
    assign bus.exc_addr  = exc_addr_q;
    assign bus.mem_valid = mem_valid;
    assign bus.mem_addr  = {addr_q[head_q], {OB{1'b0}}};
    assign bus.mem_wdata = data_q[head_q];
    assign bus.mem_be    = be_q[head_q];
    assign count_o       = count_q;
    assign empty_o       = ~mem_valid;
endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed bench for store_buffer_unit: a DW=32 instance covers decode,
// exceptions, combining, backpressure and reset; a DW=64 instance covers sd.
module tb_store_buffer_unit;
    localparam logic [5:0] SB = 6'h28;
    localparam logic [5:0] SH = 6'h29;
    localparam logic [5:0] SW = 6'h2b;
    localparam logic [5:0] SD = 6'h3f;
    localparam logic [5:0] LW = 6'h23;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ld32 = '0;
    logic [31:0] ld64 = '0;
    logic        hit32, hit64, emp32, emp64;
    logic [2:0]  cnt32, cnt64;
    int          n_checks = 0;
    int          n_pass = 0;

    store_buffer_unit_if #(.DW(32), .AW(32)) b32 ();
    store_buffer_unit_if #(.DW(64), .AW(32)) b64 ();

    store_buffer_unit #(.DW(32), .AW(32), .DEPTH(4)) u32 (
        .clk(clk), .rst_n(rst_n), .bus(b32.slave), .ld_addr_i(ld32),
        .ld_hit_o(hit32), .count_o(cnt32), .empty_o(emp32)
    );

    store_buffer_unit #(.DW(64), .AW(32), .DEPTH(4)) u64 (
        .clk(clk), .rst_n(rst_n), .bus(b64.slave), .ld_addr_i(ld64),
        .ld_hit_o(hit64), .count_o(cnt64), .empty_o(emp64)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        b32.st_valid = 1'b1;
        b32.st_op    = op;
        b32.st_addr  = a;
        b32.st_data  = d;
        tick();
        b32.st_valid = 1'b0;
    endtask

    task automatic st64(input logic [5:0] op, input logic [31:0] a, input logic [63:0] d);
        b64.st_valid = 1'b1;
        b64.st_op    = op;
        b64.st_addr  = a;
        b64.st_data  = d;
        tick();
        b64.st_valid = 1'b0;
    endtask

    initial begin
        b32.st_valid = 1'b0; b32.st_op = '0; b32.st_addr = '0; b32.st_data = '0; b32.mem_ready = 1'b0;
        b64.st_valid = 1'b0; b64.st_op = '0; b64.st_addr = '0; b64.st_data = '0; b64.mem_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_count", cnt32, 0);
        check("rst_mem_valid", b32.mem_valid, 0);
        check("rst_exc_valid", b32.exc_valid, 0);
        check("rst_exc_addr", b32.exc_addr, 0);
        check("rst_st_ready", b32.st_ready, 1);
        check("rst_empty", emp32, 1);
        rst_n = 1'b1;
        tick();

        // sb lane decode with memory ready
        b32.mem_ready = 1'b1;
        st32(SB, 32'h1003, 32'h0000_00AB);
        check("sb_count", cnt32, 1);
        check("sb_mem_valid", b32.mem_valid, 1);
        check("sb_mem_addr", b32.mem_addr, 32'h1000);
        check("sb_mem_be", b32.mem_be, 4'b1000);
        check("sb_mem_wdata", b32.mem_wdata, 32'hAB00_0000);
        // pop and push on the same edge; upper rt bytes must be dropped
        st32(SB, 32'h1001, 32'hFFFF_FF5A);
        check("sb2_count", cnt32, 1);
        check("sb2_mem_be", b32.mem_be, 4'b0010);
        check("sb2_mem_wdata", b32.mem_wdata, 32'h0000_5A00);
        tick();
        check("sb_drained", cnt32, 0);
        check("sb_drained_valid", b32.mem_valid, 0);

        // Misaligned stores raise a one-cycle AdES and are not queued
        st32(SH, 32'h1001, 32'h1234);
        check("sh_exc_valid", b32.exc_valid, 1);
        check("sh_exc_addr", b32.exc_addr, 32'h1001);
        check("sh_no_enqueue", cnt32, 0);
        tick();
        check("sh_exc_pulse", b32.exc_valid, 0);
        check("sh_exc_addr_hold", b32.exc_addr, 32'h1001);
        st32(SW, 32'h1002, 32'h5678);
        check("sw_exc_valid", b32.exc_valid, 1);
        check("sw_exc_addr", b32.exc_addr, 32'h1002);
        check("sw_no_enqueue", b32.mem_valid, 0);
        // Non-store opcode and sd on a 32-bit buffer are ignored
        st32(LW, 32'h1001, 32'h1);
        check("lw_ignored_exc", b32.exc_valid, 0);
        check("lw_ignored_cnt", cnt32, 0);
        st32(SD, 32'h1004, 32'h2);
        check("sd32_ignored_exc", b32.exc_valid, 0);
        check("sd32_ignored_cnt", cnt32, 0);

        // Combining with memory stalled
        b32.mem_ready = 1'b0;
        st32(SW, 32'h2000, 32'hDEAD_BEEF);
        st32(SB, 32'h3000, 32'h11);
        st32(SB, 32'h3002, 32'h22);
        check("comb_count", cnt32, 2);
        check("comb_head_addr", b32.mem_addr, 32'h2000);
        check("comb_head_be", b32.mem_be, 4'hF);
        check("comb_head_wdata", b32.mem_wdata, 32'hDEAD_BEEF);
        ld32 = 32'h3003; #1;
        check("comb_ld_hit_tail", hit32, 1);
        ld32 = 32'h2001; #1;
        check("comb_ld_hit_head", hit32, 1);
        ld32 = 32'h4000; #1;
        check("comb_ld_miss", hit32, 0);
        b32.mem_ready = 1'b1;
        tick();
        check("comb_pop_count", cnt32, 1);
        check("comb_entry1_addr", b32.mem_addr, 32'h3000);
        check("comb_entry1_be", b32.mem_be, 4'b0101);
        check("comb_entry1_wdata", b32.mem_wdata, 32'h0022_0011);
        tick();
        check("comb_empty", emp32, 1);

        // With a single entry, a store to the same word makes a new entry
        b32.mem_ready = 1'b0;
        st32(SW, 32'h3000, 32'h5566_7788);
        st32(SB, 32'h3000, 32'h99);
        check("nocomb_count", cnt32, 2);
        b32.mem_ready = 1'b1;
        tick();
        check("nocomb_second_be", b32.mem_be, 4'b0001);
        check("nocomb_second_wdata", b32.mem_wdata, 32'h0000_0099);
        tick();
        check("nocomb_empty", cnt32, 0);

        // Full buffer and backpressure
        b32.mem_ready = 1'b0;
        st32(SW, 32'h5000, 32'hA0A0_A0A0);
        st32(SW, 32'h5004, 32'hA1A1_A1A1);
        st32(SW, 32'h5008, 32'hA2A2_A2A2);
        st32(SW, 32'h500C, 32'hA3A3_A3A3);
        check("full_count", cnt32, 4);
        check("full_st_ready", b32.st_ready, 0);
        b32.st_valid = 1'b1; b32.st_op = SW; b32.st_addr = 32'h5010; b32.st_data = 32'h5555_5555;
        tick();
        check("full_held_count", cnt32, 4);
        check("full_stable_addr", b32.mem_addr, 32'h5000);
        check("full_stable_wdata", b32.mem_wdata, 32'hA0A0_A0A0);
        ld32 = 32'h5008; #1;
        check("full_ld_hit", hit32, 1);
        ld32 = 32'h5010; #1;
        check("full_ld_miss_pending", hit32, 0);
        b32.mem_ready = 1'b1;
        tick();
        check("drain1_count", cnt32, 3);
        check("drain1_addr", b32.mem_addr, 32'h5004);
        check("drain1_st_ready", b32.st_ready, 1);
        tick();
        b32.st_valid = 1'b0;
        check("drain2_count", cnt32, 3);
        check("drain2_addr", b32.mem_addr, 32'h5008);
        tick();
        check("drain3_addr", b32.mem_addr, 32'h500C);
        tick();
        check("drain4_addr", b32.mem_addr, 32'h5010);
        check("drain4_wdata", b32.mem_wdata, 32'h5555_5555);
        check("drain4_count", cnt32, 1);
        tick();
        check("drain_empty", emp32, 1);

        // Asynchronous reset with three entries queued and an exception pending
        b32.mem_ready = 1'b0;
        st32(SW, 32'h6000, 32'h1);
        st32(SW, 32'h6004, 32'h2);
        st32(SW, 32'h6008, 32'h3);
        st32(SH, 32'h6001, 32'h4);
        check("pre_rst_count", cnt32, 3);
        check("pre_rst_exc", b32.exc_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", cnt32, 0);
        check("arst_mem_valid", b32.mem_valid, 0);
        check("arst_exc_valid", b32.exc_valid, 0);
        check("arst_exc_addr", b32.exc_addr, 0);
        check("arst_st_ready", b32.st_ready, 1);
        b32.mem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_mem_valid", b32.mem_valid, 0);
        tick();
        check("post_rst_count", cnt32, 0);

        // 64-bit buffer: sd decode, sd misalignment, upper-half sw, sb lane
        st64(SD, 32'h40, 64'h0123_4567_89AB_CDEF);
        check("sd_count", cnt64, 1);
        check("sd_mem_addr", b64.mem_addr, 32'h40);
        check("sd_mem_be", b64.mem_be, 8'hFF);
        check("sd_mem_wdata", b64.mem_wdata, 64'h0123_4567_89AB_CDEF);
        st64(SD, 32'h44, 64'h1);
        check("sd_exc_valid", b64.exc_valid, 1);
        check("sd_exc_addr", b64.exc_addr, 32'h44);
        check("sd_exc_no_enqueue", cnt64, 1);
        st64(SW, 32'h44, 64'h0000_0000_CAFE_F00D);
        check("sw64_count", cnt64, 2);
        b64.mem_ready = 1'b1;
        tick();
        check("sw64_mem_addr", b64.mem_addr, 32'h40);
        check("sw64_mem_be", b64.mem_be, 8'hF0);
        check("sw64_mem_wdata", b64.mem_wdata, 64'hCAFE_F00D_0000_0000);
        tick();
        check("sw64_empty", emp64, 1);
        st64(SB, 32'h45, 64'h5A);
        check("sb64_mem_be", b64.mem_be, 8'h20);
        check("sb64_mem_wdata", b64.mem_wdata, 64'h0000_5A00_0000_0000);
        tick();
        check("sb64_empty", cnt64, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
- Parametrised successor of the store byte-enable logic.
- Accepts pipeline store requests (sb/sh/sw, plus sd when DW=64) and decodes byte enables little-endian (byte offset 0 maps to be[0]).
- Lane-shifts store data, flags misaligned stores as AdES, and queues writes in a DEPTH-entry combining write buffer that drains to data memory over a valid/ready handshake.
- Sits between the MEM stage and the data-memory port; also reports load/store address hazards so the pipeline can stall loads.

Parameters:
DW, 32, data/memory width in bits; legal values 32 or 64; NB = DW/8 byte lanes, OB = log2(NB) offset bits
AW, 32, byte-address width
DEPTH, 4, write-buffer entries; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
st_valid  in  1  store request valid
st_ready  out  1  buffer can accept; equals !full (no combinational path from mem_ready)
st_op  in  6  instruction opcode: 0x28 sb, 0x29 sh, 0x2b sw, 0x3f sd (DW=64 only)
st_addr  in  AW  store byte address
st_data  in  DW  rt value, right-justified
exc_valid  out  1  one-cycle AdES pulse
exc_addr  out  AW  BadVAddr of the last misaligned store
mem_valid  out  1  head entry valid
mem_ready  in  1  memory accepts head
mem_addr  out  AW  head word address; low OB bits zero
mem_wdata  out  DW  head data, lane-aligned
mem_be  out  NB  head byte enables
ld_addr  in  AW  load address from MEM stage
ld_hit  out  1  combinational: some valid entry has the same word address (ld_addr[AW-1:OB])
count  out  log2(DEPTH)+1  occupied entries
empty  out  1  count==0

Behaviour:
Reset:
- count=0, all entry valid bits 0, mem_valid=0, exc_valid=0, exc_addr=0, st_ready=1.
- A reset asserted mid-drain discards all entries immediately; no mem handshake completes after reset.

Accept and decode:
- Accept = st_valid & st_ready & legal store opcode.
- Non-store opcodes, or sd when DW=32, are ignored: no enqueue, no exception.
- Byte offset off = st_addr[OB-1:0].
- sb: be = 1<<off.
- sh: be = 2'b11<<off; misaligned if off[0].
- sw: be = 4'hF<<off; misaligned if off[1:0]!=0.
- sd: be = all ones; misaligned if off!=0.
- Data: wdata = st_data << (8*off), with unused bytes zero.

Exceptions:
- A misaligned accepted store is not enqueued.
- The next cycle: exc_valid=1 for exactly one cycle and exc_addr=st_addr; exc_addr holds until the next exception.

Enqueue and combining:
- A new store combines into the tail entry when all of these hold: count>=2, the tail is not the head, and the word addresses match.
- On combine: tail be |= new be; bytes with new be set take the new data; all other bytes are kept; count is unchanged.
- Otherwise the store is written at the tail and count increments.
- The head entry is never modified while presented, so mem_* stay stable while mem_valid & !mem_ready.

Drain:
- mem_valid = !empty; the head is presented directly from storage (zero-latency output).
- When mem_valid & mem_ready, the head pops the same edge.
- Entries drain in FIFO order, at most one per cycle.

Simultaneous push and pop:
- Push and pop in the same cycle leave count unchanged.
- If the buffer is full, st_ready=0 even when a pop occurs that cycle.
- A pop of the current tail in the same cycle as an incoming store to the same word gives a new entry, not a combine (covered by the count>=2 rule).

Pointers and count:
- Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count ranges 0..DEPTH; it never overflows or underflows.

ld_hit:
- Considers only entries already in the buffer, not the store being accepted this cycle.

Latency:
- An accepted store is visible on mem_* at the earliest one cycle after acceptance.

Test Plan:
- Reset: rst_n low mid-stream with 3 entries queued -> count=0, mem_valid=0, exc_valid=0, st_ready=1 immediately (asynchronous); after release the old entries never appear on mem_*.
- sb at 0x1003, st_data=0x000000AB, mem_ready=1 -> next cycle mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xAB000000; then count returns to 0.
- sh at 0x1001 -> no enqueue; exc_valid=1 for one cycle, exc_addr=0x1001. sw at 0x1002 -> same behaviour with exc_addr=0x1002.
- Combining, mem_ready=0: sw 0x2000 data 0xDEADBEEF, then sb 0x3000 data 0x11, then sb 0x3002 data 0x22 -> count=2; entry1 mem_be=4'b0101, wdata=0x00220011. With only sw 0x3000 queued (count=1), a following sb 0x3000 creates a second entry.
- Full and backpressure, DEPTH=4, mem_ready=0: four sw to distinct words -> st_ready=0, fifth store held and mem_* stable. Raise mem_ready -> entries drain in order one per cycle and the fifth store is accepted when count drops to 3. ld_addr equal to any queued word gives ld_hit=1; an unmatched address gives 0.
- DW=64: sd at 0x40 data 0x0123456789ABCDEF -> mem_be=8'hFF, wdata unchanged. sd at 0x44 -> AdES with exc_addr=0x44. sw at 0x44 -> mem_be=8'hF0, wdata = data<<32.
